// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline definitions: skid-buffer state encoding and operand-mux limits.
package riscv_pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ONE,
        ST_TWO
    } skid_state_t;

    localparam int MIN_MUX_SRC = 2;
    localparam int MAX_MUX_SRC = 16;

endpackage

// File: rtl/mux_sel_comb.sv
// Combinational N:1 word select; out-of-range selects yield a zero word and err=1.
module mux_sel_comb #(
    parameter int WIDTH = 32,
    parameter int N_SRC = 4,
    parameter int SEL_W = $clog2(N_SRC)
) (
    input  logic [N_SRC*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]       sel,
    output logic [WIDTH-1:0]       word,
    output logic                   err
);

    // Table padded to the full select range so unused codes read as zero.
    logic [WIDTH-1:0] words [2**SEL_W];

    generate
        for (genvar gi = 0; gi < 2**SEL_W; gi++) begin : g_word
            if (gi < N_SRC) begin : g_src
                assign words[gi] = in_data[gi*WIDTH +: WIDTH];
            end else begin : g_pad
                assign words[gi] = '0;
            end
        end
    endgenerate

    assign word = words[sel];
    assign err  = (int'(sel) >= N_SRC);

endmodule

// File: rtl/mux_n_1_pipe.sv
// N:1 word selector with a registered output and a 2-entry skid buffer (valid/ready, flush).
module mux_n_1_pipe
    import riscv_pipe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N_SRC = 4,
    parameter int SEL_W = $clog2(N_SRC)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic [N_SRC*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]       in_sel,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_err,
    output logic                   out_valid,
    input  logic                   out_ready
);

    generate
        if (N_SRC < MIN_MUX_SRC || N_SRC > MAX_MUX_SRC) begin : g_bad_nsrc
            $fatal(1, "mux_n_1_pipe: N_SRC=%0d outside supported range", N_SRC);
        end
        if (SEL_W != $clog2(N_SRC)) begin : g_bad_selw
            $fatal(1, "mux_n_1_pipe: SEL_W must equal clog2(N_SRC)");
        end
    endgenerate

    skid_state_t      state_reg, state_next;
    logic [WIDTH-1:0] main_data_reg, skid_data_reg;
    logic             main_err_reg, skid_err_reg;

    logic [WIDTH-1:0] sel_word;
    logic             sel_err;
    logic             in_xfer, out_xfer;
    logic             main_load_in, main_load_skid, main_clear, skid_load;

    mux_sel_comb #(
        .WIDTH (WIDTH),
        .N_SRC (N_SRC),
        .SEL_W (SEL_W)
    ) u_sel (
        .in_data (in_data),
        .sel     (in_sel),
        .word    (sel_word),
        .err     (sel_err)
    );

    // Handshake flags decode only from the state flop, so in_ready has no path from out_ready.
    assign out_valid = (state_reg != ST_EMPTY);
    assign in_ready  = (state_reg != ST_TWO);
    assign out_data  = main_data_reg;
    assign out_err   = main_err_reg;

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_EMPTY: if (in_xfer) state_next = ST_ONE;
            ST_ONE: begin
                if (out_xfer && !in_xfer)      state_next = ST_EMPTY;
                else if (in_xfer && !out_xfer) state_next = ST_TWO;
            end
            ST_TWO:   if (out_xfer) state_next = ST_ONE;
            default:  state_next = ST_EMPTY;
        endcase
        if (flush) state_next = ST_EMPTY;
    end

    always_comb begin
        main_load_in   = 1'b0;
        main_load_skid = 1'b0;
        main_clear     = 1'b0;
        skid_load      = 1'b0;
        if (flush) begin
            main_clear = 1'b0 | 1'b1;
        end else begin
            unique case (state_reg)
                ST_EMPTY: main_load_in = in_xfer;
                ST_ONE: begin
                    main_load_in = in_xfer & out_xfer;
                    main_clear   = out_xfer & ~in_xfer;
                    skid_load    = in_xfer & ~out_xfer;
                end
                ST_TWO:   main_load_skid = out_xfer;
                default:  main_clear = 1'b1;
            endcase
        end
    end

    // Main is zeroed whenever it empties so a stale word is never presented.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_data_reg <= '0;
            main_err_reg  <= 1'b0;
            skid_data_reg <= '0;
            skid_err_reg  <= 1'b0;
        end else begin
            if (main_clear) begin
                main_data_reg <= '0;
                main_err_reg  <= 1'b0;
            end else if (main_load_skid) begin
                main_data_reg <= skid_data_reg;
                main_err_reg  <= skid_err_reg;
            end else if (main_load_in) begin
                main_data_reg <= sel_word;
                main_err_reg  <= sel_err;
            end
            if (flush) begin
                skid_data_reg <= '0;
                skid_err_reg  <= 1'b0;
            end else if (skid_load) begin
                skid_data_reg <= sel_word;
                skid_err_reg  <= sel_err;
            end
        end
    end

endmodule

// File: tb/tb_mux_n_1_pipe.sv
// Drives four mux_n_1_pipe instances (N_SRC=4,3,2,16) in lock step and checks them against a queue model.
module tb_mux_n_1_pipe;

    logic         clk;
    logic         rst_n;
    logic         flush;
    logic         in_valid;
    logic         out_ready;
    logic [511:0] src;
    logic [3:0]   sel;

    logic [3:0]        ov, ir, oe;
    logic [3:0][31:0]  od;

    int checks = 0;
    int errors = 0;

    // Instance index -> number of sources and select width.
    int nsrc [4] = '{4, 3, 2, 16};
    int selw [4] = '{2, 2, 1, 4};

    typedef struct {
        logic [3:0]   sel;
        logic [511:0] d;
    } entry_t;
    entry_t q[$];

    mux_n_1_pipe #(.WIDTH(32), .N_SRC(4)) u_n4 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_data(src[4*32-1:0]), .in_sel(sel[1:0]), .in_valid(in_valid), .in_ready(ir[0]),
        .out_data(od[0]), .out_err(oe[0]), .out_valid(ov[0]), .out_ready(out_ready)
    );
    mux_n_1_pipe #(.WIDTH(32), .N_SRC(3)) u_n3 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_data(src[3*32-1:0]), .in_sel(sel[1:0]), .in_valid(in_valid), .in_ready(ir[1]),
        .out_data(od[1]), .out_err(oe[1]), .out_valid(ov[1]), .out_ready(out_ready)
    );
    mux_n_1_pipe #(.WIDTH(32), .N_SRC(2)) u_n2 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_data(src[2*32-1:0]), .in_sel(sel[0:0]), .in_valid(in_valid), .in_ready(ir[2]),
        .out_data(od[2]), .out_err(oe[2]), .out_valid(ov[2]), .out_ready(out_ready)
    );
    mux_n_1_pipe #(.WIDTH(32), .N_SRC(16)) u_n16 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_data(src), .in_sel(sel), .in_valid(in_valid), .in_ready(ir[3]),
        .out_data(od[3]), .out_err(oe[3]), .out_valid(ov[3]), .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference selection: the select is truncated to the instance's width, then range-checked.
    function automatic logic [32:0] ref_out(int n, int w, logic [3:0] s, logic [511:0] d);
        int es;
        es = int'(s) & ((1 << w) - 1);
        if (es < n) return {1'b0, d[es*32 +: 32]};
        return {1'b1, 32'h0};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sel = '0;
        for (int k = 0; k < 16; k++) src[k*32 +: 32] = 32'hA0 + 32'h11 * k;
        #3;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({ov[i], ir[i], oe[i], od[i]} !== {1'b0, 1'b1, 1'b0, 32'h0}) begin
                errors++;
                $display("FAIL reset inst%0d: valid=%0b ready=%0b err=%0b data=%h, required 0 1 0 0",
                         i, ov[i], ir[i], oe[i], od[i]);
            end
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            sel = 4'(k);
            tick();
            checks++;
            if (ov[0] !== 1'b1 || ir[0] !== 1'b1 || od[0] !== 32'hA0 + 32'h11 * k) begin
                errors++;
                $display("FAIL stream word%0d: valid=%0b ready=%0b data=%h, required 1 1 %h",
                         k, ov[0], ir[0], od[0], 32'hA0 + 32'h11 * k);
            end
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (ov[0] !== 1'b0 || od[0] !== 32'h0) begin
            errors++;
            $display("FAIL stream drain: valid=%0b data=%h, required 0 0", ov[0], od[0]);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        sel = 4'd2;
        tick();
        checks++;
        if (ov[0] !== 1'b1 || ir[0] !== 1'b1 || od[0] !== 32'hC2) begin
            errors++;
            $display("FAIL bp first: valid=%0b ready=%0b data=%h, required 1 1 c2", ov[0], ir[0], od[0]);
        end
        sel = 4'd3;
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (ov[0] !== 1'b1 || ir[0] !== 1'b0 || od[0] !== 32'hC2) begin
                errors++;
                $display("FAIL bp hold%0d: valid=%0b ready=%0b data=%h, required 1 0 c2",
                         c, ov[0], ir[0], od[0]);
            end
            if (c == 0) tick();
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (ov[0] !== 1'b1 || ir[0] !== 1'b1 || od[0] !== 32'hD3) begin
            errors++;
            $display("FAIL bp release: valid=%0b ready=%0b data=%h, required 1 1 d3", ov[0], ir[0], od[0]);
        end
        tick();
        checks++;
        if (ov[0] !== 1'b0 || od[0] !== 32'h0) begin
            errors++;
            $display("FAIL bp drain: valid=%0b data=%h, required 0 0", ov[0], od[0]);
        end
    endtask

    task automatic test_out_of_range();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        sel = 4'd3;
        tick();
        checks++;
        if (ov[1] !== 1'b1 || oe[1] !== 1'b1 || od[1] !== 32'h0) begin
            errors++;
            $display("FAIL oor sel3: valid=%0b err=%0b data=%h, required 1 1 0", ov[1], oe[1], od[1]);
        end
        checks++;
        if (oe[0] !== 1'b0 || od[0] !== 32'hD3) begin
            errors++;
            $display("FAIL oor n4 sel3: err=%0b data=%h, required 0 d3", oe[0], od[0]);
        end
        sel = 4'd1;
        tick();
        checks++;
        if (ov[1] !== 1'b1 || oe[1] !== 1'b0 || od[1] !== 32'hB1) begin
            errors++;
            $display("FAIL oor sel1: valid=%0b err=%0b data=%h, required 1 0 b1", ov[1], oe[1], od[1]);
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        sel = 4'd0;
        tick();
        sel = 4'd1;
        tick();
        checks++;
        if (ir[0] !== 1'b0 || od[0] !== 32'hA0) begin
            errors++;
            $display("FAIL flush fill: ready=%0b data=%h, required 0 a0", ir[0], od[0]);
        end
        flush = 1'b1; out_ready = 1'b1; sel = 4'd2;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ov[i] !== 1'b0 || ir[i] !== 1'b1 || od[i] !== 32'h0) begin
                errors++;
                $display("FAIL flush inst%0d: valid=%0b ready=%0b data=%h, required 0 1 0",
                         i, ov[i], ir[i], od[i]);
            end
        end
        tick();
        tick();
        checks++;
        if (ov[0] !== 1'b0) begin
            errors++;
            $display("FAIL flush ghost: valid=%0b data=%h, required valid 0", ov[0], od[0]);
        end
        in_valid = 1'b1; sel = 4'd3;
        tick();
        in_valid = 1'b0;
        checks++;
        if (ov[0] !== 1'b1 || od[0] !== 32'hD3) begin
            errors++;
            $display("FAIL flush resume: valid=%0b data=%h, required 1 d3", ov[0], od[0]);
        end
        tick();
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        sel = 4'd0;
        tick();
        sel = 4'd1;
        tick();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ov[i] !== 1'b0 || ir[i] !== 1'b1 || od[i] !== 32'h0 || oe[i] !== 1'b0) begin
                errors++;
                $display("FAIL async reset inst%0d: valid=%0b ready=%0b err=%0b data=%h, required 0 1 0 0",
                         i, ov[i], ir[i], oe[i], od[i]);
            end
        end
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1; in_valid = 1'b1; sel = 4'd2;
        tick();
        in_valid = 1'b0;
        checks++;
        if (ov[0] !== 1'b1 || od[0] !== 32'hC2) begin
            errors++;
            $display("FAIL reset resume: valid=%0b data=%h, required 1 c2", ov[0], od[0]);
        end
        tick();
        checks++;
        if (ov[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset leftover: valid=%0b data=%h, required valid 0", ov[0], od[0]);
        end
    endtask

    task automatic test_random();
        logic [32:0] e;
        logic        ev, er;
        logic        inx, outx;
        int          printed = 0;
        entry_t      ent;
        flush = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        tick();
        flush = 1'b0;
        q.delete();
        for (int cyc = 0; cyc < 10000; cyc++) begin
            for (int k = 0; k < 16; k++) src[k*32 +: 32] = $urandom;
            sel       = 4'($urandom_range(0, 15));
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 49) == 0);
            ev = (q.size() > 0);
            er = (q.size() < 2);
            for (int i = 0; i < 4; i++) begin
                e = ev ? ref_out(nsrc[i], selw[i], q[0].sel, q[0].d) : 33'h0;
                checks++;
                if ({ov[i], ir[i], oe[i], od[i]} !== {ev, er, e[32], e[31:0]}) begin
                    errors++;
                    if (printed < 20) begin
                        printed++;
                        $display("FAIL random cyc%0d inst%0d: valid=%0b ready=%0b err=%0b data=%h, required %0b %0b %0b %h",
                                 cyc, i, ov[i], ir[i], oe[i], od[i], ev, er, e[32], e[31:0]);
                    end
                end
            end
            if (flush) begin
                q.delete();
            end else begin
                inx  = in_valid && (q.size() < 2);
                outx = out_ready && (q.size() > 0);
                if (outx) void'(q.pop_front());
                if (inx) begin
                    ent.sel = sel;
                    ent.d   = src;
                    q.push_back(ent);
                end
            end
            tick();
        end
        flush = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_out_of_range();
        test_flush();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
